// File: rtl/rr_mux_reg_if.sv
// Request/response bundle for rr_mux_reg: N requesters in, one registered output port.
interface rr_mux_reg_if #(
    parameter int WIDTH = 32,
    parameter int N     = 3
);
    localparam int SELW = $clog2(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               force_en;
    logic [SELW-1:0]    force_sel;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;

    modport master (
        output in_valid, in_data, force_en, force_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, force_en, force_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_mux_reg.sv
// N-way round-robin (or forced-select) mux feeding a one-entry registered output buffer.
module rr_mux_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 3
) (
    input  logic      clk,
    input  logic      reset,
    rr_mux_reg_if.slave bus
);
    localparam int              SELW  = $clog2(N);
    localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);

    logic [SELW-1:0]  ptr;
    logic             can_accept;
    logic [N-1:0]     rr_grant;
    logic [N-1:0]     fx_grant;
    logic [N-1:0]     grant;
    logic [N-1:0]     ready;
    logic [SELW:0]    rr_idx;
    logic             rr_found;
    logic [SELW-1:0]  win_idx;
    logic [WIDTH-1:0] win_data;
    logic [SELW-1:0]  next_ptr;
    logic             xfer;

    assign can_accept = !bus.out_valid || bus.out_ready;

    // Scan ptr, ptr+1, ... modulo N; the extra index bit keeps the wrap exact for any N.
    always_comb begin
        rr_grant = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < N; k++) begin
            rr_idx = {1'b0, ptr} + (SELW+1)'(k);
            if (rr_idx >= N_EXT) begin
                rr_idx = rr_idx - N_EXT;
            end
            if (!rr_found && bus.in_valid[rr_idx[SELW-1:0]]) begin
                rr_grant[rr_idx[SELW-1:0]] = 1'b1;
                rr_found = 1'b1;
            end
        end
    end

    // Out-of-range forced index grants nothing rather than indexing past the vector.
    always_comb begin
        fx_grant = '0;
        if ({1'b0, bus.force_sel} < N_EXT) begin
            fx_grant[bus.force_sel] = bus.in_valid[bus.force_sel];
        end
    end

    assign grant        = bus.force_en ? fx_grant : rr_grant;
    assign ready        = grant & {N{can_accept && !reset}};
    assign bus.in_ready = ready;
    assign xfer         = |ready;

    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                win_idx  = SELW'(i);
                win_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign next_ptr = (win_idx == SELW'(N-1)) ? '0 : win_idx + SELW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            ptr           <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= win_data;
            bus.out_sel   <= win_idx;
            if (!bus.force_en) begin
                ptr <= next_ptr;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: N=3 against a spec-level model, plus N=2 and N=5 rotation checks.
module tb_rr_mux_reg;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad   = 0;

    rr_mux_reg_if #(.WIDTH(32), .N(3)) bus3 ();
    rr_mux_reg_if #(.WIDTH(8),  .N(2)) bus2 ();
    rr_mux_reg_if #(.WIDTH(16), .N(5)) bus5 ();

    rr_mux_reg #(.WIDTH(32), .N(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));
    rr_mux_reg #(.WIDTH(8),  .N(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
    rr_mux_reg #(.WIDTH(16), .N(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rr_word(int c);
        case (c)
            0:       return 32'hA0;
            1:       return 32'hB1;
            default: return 32'hC2;
        endcase
    endfunction

    // Model state for the N=3 instance.
    int          m_ptr   = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    int          m_sel   = 0;
    logic [2:0]  pend_g  = '0;
    bit          pend_ok = 1'b0;

    always @(negedge clk) begin : cmp
        logic [2:0] g;
        int         fs;
        int         c;
        bit         can;
        if (reset) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 0;
            pend_ok = 1'b0;
            chk("cmp_rst_in_ready", bus3.in_ready, 3'b000);
            chk("cmp_rst_out_valid", bus3.out_valid, 1'b0);
        end else begin
            can = !m_valid || bus3.out_ready;
            g   = '0;
            if (bus3.force_en) begin
                fs = int'(bus3.force_sel);
                if (fs < 3 && bus3.in_valid[fs]) g[fs] = 1'b1;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    c = (m_ptr + k) % 3;
                    if (g == 3'b000 && bus3.in_valid[c]) g[c] = 1'b1;
                end
            end
            if (!can) g = '0;
            chk("cmp_in_ready", bus3.in_ready, g);
            chk("cmp_out_valid", bus3.out_valid, m_valid);
            chk("cmp_out_data", bus3.out_data, m_data);
            chk("cmp_out_sel", bus3.out_sel, m_sel);
            pend_g  = g;
            pend_ok = 1'b1;
        end
        chk("onehot3", $onehot0(bus3.in_ready), 1'b1);
        chk("onehot2", $onehot0(bus2.in_ready), 1'b1);
        chk("onehot5", $onehot0(bus5.in_ready), 1'b1);
        chk("sel5_range", bus5.out_sel < 3'd5, 1'b1);
        assert ($onehot0(bus5.in_ready)) else $error("in_ready5 not one-hot");
    end

    always @(posedge clk) begin : mdl
        if (!reset && pend_ok) begin
            if (pend_g != 3'b000) begin
                for (int i = 0; i < 3; i++) begin
                    if (pend_g[i]) begin
                        m_data = bus3.in_data[i*32 +: 32];
                        m_sel  = i;
                        if (!bus3.force_en) m_ptr = (i + 1) % 3;
                    end
                end
                m_valid = 1'b1;
            end else if (m_valid && bus3.out_ready) begin
                m_valid = 1'b0;
            end
        end
        pend_ok = 1'b0;
    end

    initial begin
        bus3.in_valid  = 3'b111;
        bus3.in_data   = {32'hC2, 32'hB1, 32'hA0};
        bus3.force_en  = 1'b0;
        bus3.force_sel = 2'd0;
        bus3.out_ready = 1'b1;
        bus2.in_valid  = 2'b11;
        bus2.in_data   = {8'h11, 8'h10};
        bus2.force_en  = 1'b0;
        bus2.force_sel = 1'b0;
        bus2.out_ready = 1'b1;
        bus5.in_valid  = 5'b11111;
        bus5.in_data   = {16'h104, 16'h103, 16'h102, 16'h101, 16'h100};
        bus5.force_en  = 1'b0;
        bus5.force_sel = 3'd0;
        bus5.out_ready = 1'b1;
        reset = 1'b1;

        cyc();
        cyc();
        chk("rst_in_ready", bus3.in_ready, 3'b000);
        chk("rst_out_valid", bus3.out_valid, 1'b0);
        chk("rst_out_data", bus3.out_data, 32'h0);
        chk("rst_out_sel", bus3.out_sel, 2'd0);
        reset = 1'b0;
        #1;
        chk("rr_first_ready", bus3.in_ready, 3'b001);

        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rr_valid", bus3.out_valid, 1'b1);
            chk("rr_sel", bus3.out_sel, i % 3);
            chk("rr_data", bus3.out_data, rr_word(i % 3));
        end
        chk("model_ptr_rr", m_ptr, 0);

        // Back-pressure with a known word parked in the buffer.
        bus3.in_valid = 3'b001;
        bus3.in_data  = {32'hC2, 32'hB1, 32'hDEADBEEF};
        cyc();
        chk("bp_load", bus3.out_data, 32'hDEADBEEF);
        bus3.out_ready = 1'b0;
        bus3.in_valid  = 3'b111;
        bus3.in_data   = {32'h22222222, 32'h11111111, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("bp_data", bus3.out_data, 32'hDEADBEEF);
            chk("bp_valid", bus3.out_valid, 1'b1);
            chk("bp_ready", bus3.in_ready, 3'b000);
        end
        chk("model_ptr_bp", m_ptr, 1);
        bus3.out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", bus3.in_ready, 3'b010);
        cyc();
        chk("bp_refill_valid", bus3.out_valid, 1'b1);
        chk("bp_refill_sel", bus3.out_sel, 2'd1);
        chk("bp_refill_data", bus3.out_data, 32'h11111111);

        // Skip and wrap from ptr=2.
        bus3.in_valid = 3'b011;
        #1;
        chk("wrap_ready", bus3.in_ready, 3'b001);
        cyc();
        chk("wrap_sel", bus3.out_sel, 2'd0);
        chk("model_ptr_wrap", m_ptr, 1);
        bus3.in_valid = 3'b010;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("only1_sel", bus3.out_sel, 2'd1);
            chk("only1_valid", bus3.out_valid, 1'b1);
        end
        bus3.in_valid = 3'b001;
        cyc();
        chk("pre_fix_sel", bus3.out_sel, 2'd0);

        // Fixed mode: ptr must survive untouched (1).
        bus3.force_en  = 1'b1;
        bus3.force_sel = 2'd2;
        bus3.in_valid  = 3'b111;
        #1;
        chk("fix_ready", bus3.in_ready, 3'b100);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("fix_sel", bus3.out_sel, 2'd2);
            chk("fix_data", bus3.out_data, 32'h22222222);
            chk("fix_ready_loop", bus3.in_ready, 3'b100);
        end
        chk("model_ptr_fix", m_ptr, 1);
        bus3.force_sel = 2'd3;
        #1;
        chk("fix_oob_ready", bus3.in_ready, 3'b000);
        cyc();
        chk("fix_oob_drain", bus3.out_valid, 1'b0);
        chk("fix_oob_hold_sel", bus3.out_sel, 2'd2);
        bus3.force_en = 1'b0;
        #1;
        chk("rr_resume_ready", bus3.in_ready, 3'b010);
        cyc();
        chk("rr_resume_sel", bus3.out_sel, 2'd1);

        // Reset mid-stream clears the buffer without a clock edge.
        cyc();
        chk("mid_pre_valid", bus3.out_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", bus3.out_valid, 1'b0);
        chk("mid_rst_data", bus3.out_data, 32'h0);
        chk("mid_rst_ready", bus3.in_ready, 3'b000);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("post_rst_ready", bus3.in_ready, 3'b001);

        // Mixed vectors; the model carries the expectations.
        for (int i = 0; i < 24; i++) begin
            bus3.in_valid  = 3'((i * 5 + 3) % 8);
            bus3.out_ready = (i % 4) != 3;
            bus3.force_en  = (i % 7) >= 5;
            bus3.force_sel = 2'(i % 4);
            bus3.in_data   = {32'(i * 32'h1000 + 2), 32'(i * 32'h1000 + 1), 32'(i * 32'h1000)};
            cyc();
        end

        // Parameter sweep: fresh reset, then full-load rotation.
        bus3.in_valid  = 3'b000;
        bus3.out_ready = 1'b1;
        bus3.force_en  = 1'b0;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("sweep2_sel", bus2.out_sel, i % 2);
            chk("sweep2_data", bus2.out_data, 8'h10 + 8'(i % 2));
            chk("sweep5_sel", bus5.out_sel, i % 5);
            chk("sweep5_data", bus5.out_data, 16'h100 + 16'(i % 5));
            chk("sweep5_valid", bus5.out_valid, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised N-way successor to the datapath 3:1 select mux, used where several requesters share one downstream port (e.g. fetch/load/store onto the shared memory interface).
- Selects one input per cycle by round-robin arbitration, or by a forced select in fixed mode.
- Registers the winner into a one-entry output buffer with a valid/ready handshake.
- Latency is 1 cycle; sustained throughput is 1 transfer/cycle.

Parameters:
- WIDTH, 32, data width per channel.
- N, 3, number of input channels (2..16).
- SELW, $clog2(N), select/index width (localparam, derived, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; at most one bit high in any cycle.
- force_en  input  1  1 = fixed-select mode; 0 = round-robin mode.
- force_sel  input  SELW  channel index used when force_en=1.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  registered payload.
- out_sel  output  SELW  registered index of the channel that produced out_data.

Behaviour:
- Reset (async, active-high, immediate): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
- Reset asserted mid-transfer discards the buffered word. No transfer completes while reset is high; in_ready is all zeros during reset.
- can_accept = !out_valid | out_ready. The buffer refills in the same cycle it drains, so there are no bubbles.
- Round-robin mode (force_en=0):
  - Candidate = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - grant = one-hot of the candidate; all zeros if no in_valid bit is set.
- Fixed mode (force_en=1):
  - grant[force_sel] = in_valid[force_sel]; all other bits are 0.
  - force_sel >= N gives grant = 0 and no acceptance, with no X propagation.
- in_ready = grant & {N{can_accept}}. This is combinational from in_valid, force_en, force_sel, out_valid, out_ready and ptr.
- Transfer on channel i occurs at a clock edge when in_valid[i] & in_ready[i]. That edge:
  - sets out_data = channel i data, out_sel = i, out_valid = 1;
  - sets ptr = (i+1) mod N, but only in round-robin mode.
- Fixed-mode transfers leave ptr unchanged.
- ptr wraps from N-1 to 0. For non-power-of-2 N, ptr never takes values >= N.
- If out_valid & out_ready and no input transfers, out_valid becomes 0. out_data and out_sel hold their last values.
- If out_valid & !out_ready (stall), out_data, out_sel and out_valid hold, in_ready=0, and ptr holds.
- Simultaneous drain and refill: out_valid stays 1 and the new word replaces the old on the same edge.
- Switching force_en mid-stream takes effect the same cycle. Round-robin resumes from the preserved ptr.
- Inputs are not required to hold stable. A channel that drops in_valid before being granted loses its turn without penalty.
- Output payload is sourced only from the register; there is no combinational in→out path.

Test Plan:
- Reset: hold reset high with all in_valid=1 → in_ready=0, out_valid=0, out_data=0, out_sel=0. Assert reset mid-stream while out_valid=1 → out_valid=0 immediately, with no clock edge needed.
- Round-robin fairness (N=3, WIDTH=32): in_valid=3'b111 with data A0/B1/C2, out_ready=1 continuously → out_sel sequence 0,1,2,0,1,2, one word per cycle, first out_valid one cycle after the first accept.
- Skip and wrap: ptr=2 and in_valid=3'b011 → channel 0 granted, next ptr=1. With only in_valid[1]=1 thereafter → channel 1 granted on every cycle.
- Back-pressure: buffer holds 0xDEADBEEF with out_ready=0 for 4 cycles → out_data stable, in_ready=0, ptr unchanged. Raise out_ready → drain and refill on the same edge, out_valid stays 1.
- Fixed mode: force_en=1, force_sel=2, in_valid=3'b111 → only in_ready[2] toggles, out_sel=2 on every word, ptr unchanged. force_sel=3 → in_ready=0 and out_valid falls after the drain.
- Parameter sweep: N=2 with WIDTH=8, and N=5 with WIDTH=16 → alternation and 5-way rotation, ptr never reaches 5, in_ready is one-hot or zero in every cycle (assertion).
